// File: rtl/pwm_servo_driver.sv
// Dual-channel servo PWM generator with a fixed frame period.
// Duty commands are sampled at frame boundaries and slew-limited before use.
module pwm_servo_driver #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_CYCLES    = 50000,
    parameter int unsigned STEP_CYCLES   = 196,
    parameter int unsigned SLEW_MAX      = 8,
    parameter int unsigned CNT_W         = 20
) (
    input  logic       iClock,
    input  logic       iReset,
    input  logic [7:0] iXduty,
    input  logic [7:0] iYduty,
    input  logic       iEnable,
    output logic       oXpwm,
    output logic       oYpwm,
    output logic       oPeriodStart,
    output logic [7:0] oXapplied,
    output logic [7:0] oYapplied
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [CNT_W-1:0] MIN_W    = CNT_W'(MIN_CYCLES);
    localparam logic [CNT_W-1:0] STEP_W   = CNT_W'(STEP_CYCLES);
    localparam logic [8:0]       SLEW_MAG = 9'(SLEW_MAX);
    localparam logic [7:0]       SLEW_INC = 8'(SLEW_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             boundary;
    logic [7:0]       x_applied;
    logic [7:0]       y_applied;
    logic [7:0]       x_new;
    logic [7:0]       y_new;
    logic [CNT_W-1:0] x_width;
    logic [CNT_W-1:0] y_width;
    logic [CNT_W-1:0] x_width_next;
    logic [CNT_W-1:0] y_width_next;
    logic             en_q;
    logic             en_next;
    logic             x_pwm;
    logic             y_pwm;
    logic             period_start;

    function automatic logic [7:0] slew(input logic [7:0] target, input logic [7:0] cur);
        logic signed [8:0] diff;
        logic [8:0]        mag;
        diff = $signed({1'b0, target}) - $signed({1'b0, cur});
        mag  = diff[8] ? $unsigned(-diff) : $unsigned(diff);
        if (SLEW_MAX == 0 || mag <= SLEW_MAG)
            return target;
        else if (!diff[8])
            return cur + SLEW_INC;
        else
            return cur - SLEW_INC;
    endfunction

    always_comb begin
        boundary     = (cnt == LAST_CNT);
        cnt_next     = boundary ? '0 : cnt + CNT_W'(1);
        x_new        = slew(iXduty, x_applied);
        y_new        = slew(iYduty, y_applied);
        x_width_next = x_width;
        y_width_next = y_width;
        en_next      = en_q;
        if (boundary) begin
            x_width_next = MIN_W + CNT_W'(x_new) * STEP_W;
            y_width_next = MIN_W + CNT_W'(y_new) * STEP_W;
            en_next      = iEnable;
        end
    end

    // PWM flops compare against next-cycle state so the registered output
    // lines up with cnt: high for cnt = 0 .. width-1.
    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            cnt          <= LAST_CNT;
            x_applied    <= '0;
            y_applied    <= '0;
            x_width      <= MIN_W;
            y_width      <= MIN_W;
            en_q         <= 1'b0;
            x_pwm        <= 1'b0;
            y_pwm        <= 1'b0;
            period_start <= 1'b0;
        end else begin
            cnt          <= cnt_next;
            x_width      <= x_width_next;
            y_width      <= y_width_next;
            en_q         <= en_next;
            x_pwm        <= en_next && (cnt_next < x_width_next);
            y_pwm        <= en_next && (cnt_next < y_width_next);
            period_start <= boundary;
            if (boundary) begin
                x_applied <= x_new;
                y_applied <= y_new;
            end
        end
    end

    assign oXpwm        = x_pwm;
    assign oYpwm        = y_pwm;
    assign oPeriodStart = period_start;
    assign oXapplied    = x_applied;
    assign oYapplied    = y_applied;

endmodule
